// File: rtl/counter_pkg.sv
// Shared definitions for the LED counter and its sequence checker.
package counter_pkg;

  // Default LED bus width, shared with the Lab counter.
  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/change_detect.sv
// Samples the observed LED bus and flags a change between consecutive samples.
module change_detect #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] led_in,
  output logic [WIDTH-1:0] led_q,
  output logic [WIDTH-1:0] led_prev,
  output logic             chg
);

  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] prev_q, prev_d;

  // Next sample and previous sample shift along every cycle.
  always_comb begin
    cur_d  = led_in;
    prev_d = cur_q;
  end

  // Two-stage sample register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_q  <= '0;
      prev_q <= '0;
    end else begin
      cur_q  <= cur_d;
      prev_q <= prev_d;
    end
  end

  assign led_q    = cur_q;
  assign led_prev = prev_q;
  assign chg      = (cur_q != prev_q);

endmodule

// File: rtl/led_count_checker.sv
// Reader side of the LED counter: locks onto a +1 sequence, flags skips and
// stalls, counts errors and reports how long each value was held.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | checking disabled, match counter cleared
// ST_SEARCH  | counting consecutive +1 steps until LOCK_CNT is reached
// ST_LOCKED  | every change must equal expected; stalls are timed out
module led_count_checker
  import counter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOCK_CNT = 2,
  parameter int TIMEOUT  = 32,
  parameter int DWELL_W  = 16,
  parameter int ERR_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               err_clr,
  input  logic [WIDTH-1:0]   led_in,
  output logic               locked,
  output logic               err_pulse,
  output logic [ERR_W-1:0]   err_count,
  output logic               dwell_valid,
  output logic [DWELL_W-1:0] dwell_cycles,
  output logic [WIDTH-1:0]   expected
);

  localparam int MW = $clog2(LOCK_CNT + 1);

  logic [WIDTH-1:0]   led_q, led_prev;
  logic               chg;

  state_t             state_q, state_d;
  logic [MW-1:0]      match_q, match_d, match_inc;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [DWELL_W-1:0] dwell_cycles_q, dwell_cycles_d;
  logic [WIDTH-1:0]   expected_q, expected_d;
  logic               err_pulse_q, err_pulse_d;
  logic               dwell_valid_q, dwell_valid_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;

  change_detect #(.WIDTH(WIDTH)) u_change_detect (
    .clk      (clk),
    .rst      (rst),
    .led_in   (led_in),
    .led_q    (led_q),
    .led_prev (led_prev),
    .chg      (chg)
  );

  assign match_inc = match_q + MW'(1);

  // Lock/check state machine; enable low wins over everything without flagging.
  always_comb begin
    state_d        = state_q;
    match_d        = match_q;
    expected_d     = expected_q;
    err_pulse_d    = 1'b0;
    dwell_valid_d  = 1'b0;
    dwell_cycles_d = dwell_cycles_q;
    if (!enable) begin
      state_d = ST_IDLE;
      match_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          match_d = '0;
          state_d = ST_SEARCH;
        end
        ST_SEARCH: begin
          if (chg) begin
            if (led_q == led_prev + WIDTH'(1)) begin
              if (match_inc == MW'(LOCK_CNT)) begin
                state_d    = ST_LOCKED;
                expected_d = led_q + WIDTH'(1);
                match_d    = '0;
              end else begin
                match_d = match_inc;
              end
            end else begin
              match_d = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (chg) begin
            if (led_q == expected_q) begin
              expected_d     = led_q + WIDTH'(1);
              dwell_valid_d  = 1'b1;
              dwell_cycles_d = dwell_cnt_q;
            end else begin
              err_pulse_d = 1'b1;
              state_d     = ST_SEARCH;
              match_d     = '0;
            end
          end else if (dwell_cnt_q == DWELL_W'(TIMEOUT)) begin
            err_pulse_d = 1'b1;
            state_d     = ST_SEARCH;
            match_d     = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          match_d = '0;
        end
      endcase
    end
  end

  // Dwell timer restarts at 1 on every change; error total saturates, clear wins.
  always_comb begin
    dwell_cnt_d = dwell_cnt_q;
    if (chg) begin
      dwell_cnt_d = DWELL_W'(1);
    end else if (dwell_cnt_q != {DWELL_W{1'b1}}) begin
      dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
    end
    err_count_d = err_count_q;
    if (err_clr) begin
      err_count_d = '0;
    end else if (err_pulse_d && (err_count_q != {ERR_W{1'b1}})) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      match_q        <= '0;
      dwell_cnt_q    <= '0;
      dwell_cycles_q <= '0;
      expected_q     <= '0;
      err_pulse_q    <= 1'b0;
      dwell_valid_q  <= 1'b0;
      err_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      match_q        <= match_d;
      dwell_cnt_q    <= dwell_cnt_d;
      dwell_cycles_q <= dwell_cycles_d;
      expected_q     <= expected_d;
      err_pulse_q    <= err_pulse_d;
      dwell_valid_q  <= dwell_valid_d;
      err_count_q    <= err_count_d;
    end
  end

  assign locked       = (state_q == ST_LOCKED);
  assign err_pulse    = err_pulse_q;
  assign err_count    = err_count_q;
  assign dwell_valid  = dwell_valid_q;
  assign dwell_cycles = dwell_cycles_q;
  assign expected     = expected_q;

endmodule

// File: tb/tb_led_count_checker.sv
// Bench for led_count_checker: directed LED sequences, event scoreboard.
module tb_led_count_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        err_clr = 1'b0;
  logic [3:0]  led_in = 4'd0;
  logic        locked;
  logic        err_pulse;
  logic [7:0]  err_count;
  logic        dwell_valid;
  logic [15:0] dwell_cycles;
  logic [3:0]  expected;

  typedef struct packed {
    logic        is_err;
    logic [15:0] val;
  } evt_t;

  evt_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  led_count_checker #(
    .WIDTH(4), .LOCK_CNT(2), .TIMEOUT(32), .DWELL_W(16), .ERR_W(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .err_clr      (err_clr),
    .led_in       (led_in),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .err_count    (err_count),
    .dwell_valid  (dwell_valid),
    .dwell_cycles (dwell_cycles),
    .expected     (expected)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [3:0] val, input int hold);
    led_in = val;
    repeat (hold) tick();
  endtask

  task automatic push_dwell(input int cyc);
    exp_q.push_back('{is_err: 1'b0, val: 16'(cyc)});
  endtask

  task automatic push_err(input int cnt);
    exp_q.push_back('{is_err: 1'b1, val: 16'(cnt)});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"},       32'(locked),       32'd0);
    check({tag, "_err_pulse"},    32'(err_pulse),    32'd0);
    check({tag, "_err_count"},    32'(err_count),    32'd0);
    check({tag, "_dwell_valid"},  32'(dwell_valid),  32'd0);
    check({tag, "_dwell_cycles"}, 32'(dwell_cycles), 32'd0);
    check({tag, "_expected"},     32'(expected),     32'd0);
  endtask

  // Monitor: every err_pulse / dwell_valid must match the next queued event.
  always @(negedge clk) begin
    if (rst && (err_pulse || dwell_valid)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'({err_pulse, dwell_valid}), 32'd0);
      end else begin : pop_evt
        evt_t e;
        e = exp_q.pop_front();
        check("event_kind", 32'(err_pulse), 32'(e.is_err));
        if (e.is_err)
          check("err_count_at_pulse", 32'(err_count), 32'(e.val));
        else
          check("dwell_cycles_at_valid", 32'(dwell_cycles), 32'(e.val));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] v;
    int cnt;

    // Reset state
    #2;
    check_all_zero("reset");
    tick();
    tick();
    rst = 1'b1;
    tick();
    enable = 1'b1;
    tick();
    tick();

    // Steps every 10 cycles, 1..15, 0, 1..7; lock on the change to 2
    for (int k = 1; k <= 23; k++) begin
      if (k >= 3) push_dwell(10);
      step(4'(k), 10);
      if (k == 1) check("not_locked_after_1st_inc", 32'(locked), 32'd0);
      if (k == 2) check("locked_after_2nd_inc", 32'(locked), 32'd1);
      if (k == 16) begin
        check("wrap_locked", 32'(locked), 32'd1);
        check("wrap_expected", 32'(expected), 32'd1);
      end
    end
    check("no_err_sweep", 32'(err_count), 32'd0);

    // Skip 7 -> 9, then relock on 10, 11
    push_err(1);
    step(4'd9, 10);
    check("skip_unlocked", 32'(locked), 32'd0);
    check("skip_err_count", 32'(err_count), 32'd1);
    step(4'd10, 10);
    step(4'd11, 10);
    check("relock", 32'(locked), 32'd1);
    check("relock_expected", 32'(expected), 32'd12);

    // Continue to 5 and freeze there: stall after 32 dwell cycles
    for (int k = 12; k <= 20; k++) begin
      push_dwell(10);
      step(4'(k), 10);
    end
    push_dwell(10);
    push_err(2);
    led_in = 4'd5;
    repeat (33) tick();
    check("stall_not_early", 32'(err_pulse), 32'd0);
    tick();
    check("stall_pulse", 32'(err_pulse), 32'd1);
    check("stall_search", 32'(locked), 32'd0);
    check("dwell_cycles_hold", 32'(dwell_cycles), 32'd10);

    // Relock, then disable while locked
    step(4'd6, 3);
    step(4'd7, 3);
    check("relock_after_stall", 32'(locked), 32'd1);
    push_dwell(3);
    step(4'd8, 3);
    enable = 1'b0;
    tick();
    check("disable_unlocked", 32'(locked), 32'd0);
    check("disable_no_err", 32'(err_pulse), 32'd0);
    step(4'd10, 3);
    enable = 1'b1;
    tick();
    tick();
    check("enable_search", 32'(locked), 32'd0);
    step(4'd11, 3);
    step(4'd12, 3);
    check("enable_relock", 32'(locked), 32'd1);
    check("enable_relock_expected", 32'(expected), 32'd13);

    // Saturate err_count with back-to-back skip/relock rounds
    v = 4'd12;
    cnt = 2;
    for (int i = 0; i < 254; i++) begin
      cnt = (cnt < 255) ? cnt + 1 : 255;
      push_err(cnt);
      step(v + 4'd2, 1);
      step(v + 4'd3, 1);
      step(v + 4'd4, 1);
      v = v + 4'd4;
    end
    tick();
    check("err_saturated", 32'(err_count), 32'd255);
    check("locked_after_sat", 32'(locked), 32'd1);

    // err_clr coincident with an error
    push_err(0);
    led_in = v + 4'd2;
    tick();
    err_clr = 1'b1;
    led_in = v + 4'd3;
    tick();
    err_clr = 1'b0;
    step(v + 4'd4, 1);
    v = v + 4'd4;
    tick();
    check("clr_wins", 32'(err_count), 32'd0);

    // One more error so reset has a count to clear
    push_err(1);
    step(v + 4'd2, 1);
    step(v + 4'd3, 1);
    step(v + 4'd4, 1);
    tick();
    check("pre_reset_locked", 32'(locked), 32'd1);
    check("pre_reset_err_count", 32'(err_count), 32'd1);

    // Mid-run reset: outputs clear at once, lock needs 3,4,5
    led_in = 4'd3;
    rst = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    tick();
    check("after_reset_3", 32'(locked), 32'd0);
    step(4'd4, 3);
    check("after_reset_4", 32'(locked), 32'd0);
    step(4'd5, 3);
    check("after_reset_5", 32'(locked), 32'd1);
    check("after_reset_expected", 32'(expected), 32'd6);

    repeat (5) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
